// File: rtl/div_unit_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_unit_pkg
// Brief    : Shared constants and state encoding for the EX-stage divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package div_unit_pkg;

    localparam logic c_TRUE  = 1'b1;
    localparam logic c_FALSE = 1'b0;

    localparam logic c_DIV_RESULT_READY     = 1'b1;
    localparam logic c_DIV_RESULT_NOT_READY = 1'b0;

    localparam int c_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

endpackage : div_unit_pkg
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_unit_if
// Brief    : EX-stage request/result bundle between the pipeline and divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
);

    logic                 start;
    logic                 signed_div;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 annul;
    logic [2*WIDTH-1:0]   result;
    logic                 ready;
    logic                 div_stop;

    modport master (
        output start, signed_div, dividend, divisor, annul,
        input  result, ready, div_stop
    );

    modport slave (
        input  start, signed_div, dividend, divisor, annul,
        output result, ready, div_stop
    );

endinterface : div_unit_if
`default_nettype wire

// File: rtl/div_unit_step.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_unit_step
// Brief    : One restoring shift / trial-subtract iteration (combinational).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quot_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quot_out
);

    logic [WIDTH:0]   w_upper;
    logic [WIDTH+1:0] w_diff;
    logic             w_unused_top;

    assign w_upper = {rem_in, quot_in[WIDTH-1]};
    assign w_diff  = {1'b0, w_upper} - {2'b00, divisor};

    // The remainder stays below the divisor, so a successful subtract never sets bit WIDTH.
    assign w_unused_top = w_diff[WIDTH];

    always_comb begin
        rem_out  = w_upper[WIDTH-1:0];
        quot_out = {quot_in[WIDTH-2:0], 1'b0};
        if (!w_diff[WIDTH+1]) begin
            rem_out  = w_diff[WIDTH-1:0];
            quot_out = {quot_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule : div_unit_step
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : div_unit
// Brief    : Multi-cycle radix-2 restoring DIV/DIVU with EX stall request.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    div_unit_if.slave    bus
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t          r_state;
    div_state_t          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_quot;
    logic [WIDTH-1:0]    r_rem;
    logic [WIDTH-1:0]    r_dvs;
    logic                r_quot_neg;
    logic                r_rem_neg;
    logic [2*WIDTH-1:0]  r_result;

    logic [WIDTH-1:0]    w_abs_a;
    logic [WIDTH-1:0]    w_abs_b;
    logic [WIDTH-1:0]    w_step_rem;
    logic [WIDTH-1:0]    w_step_quot;
    logic [WIDTH-1:0]    w_quot_fix;
    logic [WIDTH-1:0]    w_rem_fix;
    logic                w_divisor_zero;
    logic                w_ready;

    assign w_divisor_zero = (bus.divisor == '0);

    assign w_abs_a = (bus.signed_div && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign w_abs_b = (bus.signed_div && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

    div_unit_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .rem_in   (r_rem),
        .quot_in  (r_quot),
        .divisor  (r_dvs),
        .rem_out  (w_step_rem),
        .quot_out (w_step_quot)
    );

    // Sign correction applies to the final iteration's output as it is captured.
    assign w_quot_fix = r_quot_neg ? -w_step_quot : w_step_quot;
    assign w_rem_fix  = r_rem_neg  ? -w_step_rem  : w_step_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DIV_FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.annul) begin
            w_state_nxt = DIV_FREE;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    if (bus.start) begin
                        w_state_nxt = w_divisor_zero ? DIV_BY_ZERO : DIV_ON;
                    end
                end
                DIV_BY_ZERO: w_state_nxt = DIV_END;
                DIV_ON: begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = DIV_END;
                    end
                end
                DIV_END: begin
                    if (!bus.start) begin
                        w_state_nxt = DIV_FREE;
                    end
                end
                default: w_state_nxt = DIV_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_quot_neg <= c_FALSE;
            r_rem_neg  <= c_FALSE;
            r_result   <= '0;
        end else if (!bus.annul) begin
            case (r_state)
                DIV_FREE: begin
                    if (bus.start && !w_divisor_zero) begin
                        r_quot     <= w_abs_a;
                        r_dvs      <= w_abs_b;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_quot_neg <= bus.signed_div && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_rem_neg  <= bus.signed_div && bus.dividend[WIDTH-1];
                    end
                end
                DIV_BY_ZERO: begin
                    r_result <= '0;
                end
                DIV_ON: begin
                    r_quot <= w_step_quot;
                    r_rem  <= w_step_rem;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_result <= {w_rem_fix, w_quot_fix};
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_ready = (r_state == DIV_END) ? c_DIV_RESULT_READY : c_DIV_RESULT_NOT_READY;

    assign bus.ready    = w_ready;
    assign bus.result   = r_result;
    assign bus.div_stop = bus.start & ~w_ready & ~bus.annul;

endmodule : div_unit
`default_nettype wire
